div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 27 ++
 rtl/div_unit_step.sv | 20 ++
 rtl/div_unit.sv | 124 ++++++++++++
 tb/tb_div_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, iteration count, result width
// and the final sign-correction helper.
package div_unit_pkg;

    localparam int unsigned DivCycles = 32;
    localparam int unsigned DWordW    = 64;

    typedef logic [DWordW-1:0] dword_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } div_state_e;

    // Packs {remainder, quotient} after applying the signed-result corrections.
    function automatic dword_t fix_result(input logic [31:0] quo, input logic [31:0] rem,
                                          input logic neg_quo, input logic neg_rem);
        logic [31:0] q;
        logic [31:0] r;
        q = neg_quo ? -quo : quo;
        r = neg_rem ? -rem : rem;
        return {r, q};
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring division iteration (purely combinational).
module div_step (
    input  logic [31:0] rem_i,
    input  logic        dvd_msb_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] rem_o,
    output logic        q_bit_o
);

    logic [32:0] shifted;
    logic [32:0] diff;

    assign shifted = {rem_i, dvd_msb_i};
    assign diff    = shifted - {1'b0, divisor_i};

    // Partial remainder is always below the divisor, so bit 32 of the difference is its sign.
    assign q_bit_o = ~diff[32];
    assign rem_o   = diff[32] ? shifted[31:0] : diff[31:0];

endmodule

// File: rtl/div_unit.sv
// 32-bit signed/unsigned iterative restoring divider, result {remainder, quotient}.
// Compile option DIV_ZERO_FAST_EN: divide-by-zero completes one cycle after start.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DivCycles
) (
    input  logic         clk_i,
    input  logic         resetn_i,
    input  logic         start_i,
    input  logic         div_s_i,
    input  logic [31:0]  opr1_i,
    input  logic [31:0]  opr2_i,
    input  logic         cancel_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [63:0]  divres_o
);

    div_state_e  state_q;
    logic [5:0]  cnt_q;
    logic [31:0] dvd_q;
    logic [31:0] dsr_q;
    logic [31:0] rem_q;
    logic        div_s_q;
    logic        sgn1_q;
    logic        sgn2_q;
    logic        busy_q;
    logic        done_q;
    dword_t      divres_q;

    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [31:0] step_rem;
    logic        step_q_bit;
    logic        zero_fast;

    assign mag1 = (div_s_i && opr1_i[31]) ? -opr1_i : opr1_i;
    assign mag2 = (div_s_i && opr2_i[31]) ? -opr2_i : opr2_i;

`ifdef DIV_ZERO_FAST_EN
    assign zero_fast = (opr2_i == 32'd0);
`else
    assign zero_fast = 1'b0;
`endif

    div_step u_div_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[31]),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q_bit)
    );

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            div_s_q  <= 1'b0;
            sgn1_q   <= 1'b0;
            sgn2_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            divres_q <= '0;
        end else if (cancel_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        div_s_q <= div_s_i;
                        sgn1_q  <= opr1_i[31];
                        sgn2_q  <= opr2_i[31];
                        dvd_q   <= mag1;
                        dsr_q   <= mag2;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        if (zero_fast) begin
                            state_q  <= StDone;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            divres_q <= fix_result(32'hFFFF_FFFF, mag1,
                                                   div_s_i & (opr1_i[31] ^ opr2_i[31]),
                                                   div_s_i & opr1_i[31]);
                        end else begin
                            state_q <= StCalc;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= StIdle;
                        done_q  <= 1'b0;
                    end
                end
                StCalc: begin
                    rem_q <= step_rem;
                    dvd_q <= {dvd_q[30:0], step_q_bit};
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'(DIV_CYCLES - 1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    divres_q <= fix_result(dvd_q, rem_q, div_s_q & (sgn1_q ^ sgn2_q),
                                           div_s_q & sgn1_q);
                    state_q  <= StDone;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign divres_o = divres_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected result and done cycle, monitor checks.
module tb_div_unit;

    localparam int Lat = 34;
`ifdef DIV_ZERO_FAST_EN
    localparam int ZeroLat = 1;
`else
    localparam int ZeroLat = 34;
`endif

    logic        clk;
    logic        resetn;
    logic        start;
    logic        div_s;
    logic [31:0] opr1;
    logic [31:0] opr2;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [63:0] divres;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    logic [63:0] exp_q[$];
    int          cyc_q[$];

    div_unit #(.DIV_CYCLES(32)) dut (
        .clk_i    (clk),
        .resetn_i (resetn),
        .start_i  (start),
        .div_s_i  (div_s),
        .opr1_i   (opr1),
        .opr2_i   (opr2),
        .cancel_i (cancel),
        .busy_o   (busy),
        .done_o   (done),
        .divres_o (divres)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result and its cycle.
    always @(negedge clk) begin
        if (resetn && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                logic [63:0] e;
                int          c;
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                check("divres", divres, e);
                check("done_cycle", 64'(cyc), 64'(c));
            end
        end
    end

    task automatic drive(input logic s, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        div_s = s;
        opr1  = a;
        opr2  = b;
    endtask

    task automatic expect_res(input logic [63:0] e, input int lat);
        exp_q.push_back(e);
        cyc_q.push_back(cyc + lat);
    endtask

    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] e, input int lat);
        @(negedge clk);
        drive(s, a, b);
        expect_res(e, lat);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
            exp_q.delete();
            cyc_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        div_s  = 1'b0;
        opr1   = '0;
        opr2   = '0;
        cancel = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_divres", divres, 64'd0);
        resetn = 1'b1;

        // Unsigned 100/7 with busy window checks
        @(negedge clk);
        drive(1'b0, 32'd100, 32'd7);
        expect_res({32'd2, 32'd14}, Lat);
        @(negedge clk);
        start = 1'b0;
        check("busy_t1", 64'(busy), 64'd1);
        repeat (32) @(negedge clk);
        check("busy_t33", 64'(busy), 64'd1);
        @(negedge clk);
        check("busy_t34", 64'(busy), 64'd0);
        check("done_t34", 64'(done), 64'd1);
        drain();

        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, Lat);
        drain();
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, Lat);
        drain();
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, Lat);
        drain();
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, Lat);
        drain();
        run_op(1'b0, 32'h8000_0000, 32'd7, {32'd2, 32'h1249_2492}, Lat);
        drain();
        run_op(1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, ZeroLat);
        drain();

        // Cancel at T+10, then restart immediately
        @(negedge clk);
        drive(1'b0, 32'd100, 32'd7);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'd0);
        check("cancel_done", 64'(done), 64'd0);
        check("cancel_divres_kept", divres, {32'd5, 32'hFFFF_FFFF});
        drive(1'b0, 32'd100, 32'd7);
        expect_res({32'd2, 32'd14}, Lat);
        @(negedge clk);
        start = 1'b0;
        drain();

        // Back-to-back: start held through busy (ignored) and accepted in DONE
        @(negedge clk);
        drive(1'b1, 32'hFFFF_FFF9, 32'd2);
        expect_res({32'hFFFF_FFFF, 32'hFFFF_FFFD}, Lat);
        @(negedge clk);
        drive(1'b0, 32'd100, 32'd7);
        repeat (33) @(negedge clk);
        check("b2b_done_first", 64'(done), 64'd1);
        expect_res({32'd2, 32'd14}, Lat);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_second", 64'(busy), 64'd1);
        drain();

        // Asynchronous reset mid-operation
        @(negedge clk);
        drive(1'b0, 32'd100, 32'd7);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_divres", divres, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
